// File: rtl/matmul_stream_core_if.sv
// rtl/matmul_stream_core_if.sv - operand and result stream bundle for matmul_stream_core
interface matmul_stream_core_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_last;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The core: consumes operands, produces results
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/matmul_stream_core.sv
// rtl/matmul_stream_core.sv - streaming M x K by K x N matrix multiply with accumulate
module matmul_stream_core #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 accumulate,
  matmul_stream_core_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int NA = M * K;
  localparam int NB = K * N;
  localparam int NC = M * N;
  localparam int AW = (NA > 1) ? $clog2(NA) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int LW = (AW > BW) ? AW : BW;
  localparam int PW = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPUTE,
    S_OUT
  } state_t;

  state_t                   state;
  logic [LW-1:0]            cnt;
  logic [KW-1:0]            k_idx;
  logic [CW-1:0]            o_idx;
  logic signed [DATA_W-1:0] a_mem [NA];
  logic signed [DATA_W-1:0] b_mem [NB];
  logic signed [ACC_W-1:0]  acc [NC];
  logic signed [ACC_W-1:0]  acc_nxt [NC];
  logic                     ovf_step;

  logic signed [DATA_W-1:0] a_op;
  logic signed [DATA_W-1:0] b_op;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;

  // One MAC step for every C element at inner index k_idx, plus the overflow of any add
  always_comb begin
    ovf_step = 1'b0;
    a_op     = '0;
    b_op     = '0;
    prod     = '0;
    prod_ext = '0;
    for (int c = 0; c < NC; c++) begin
      a_op       = a_mem[AW'((c / N) * K + int'(k_idx))];
      b_op       = b_mem[BW'(int'(k_idx) * N + (c % N))];
      prod       = PW'(a_op) * PW'(b_op);
      prod_ext   = ACC_W'(prod);
      acc_nxt[c] = acc[c] + prod_ext;
      if ((acc[c][ACC_W-1] == prod_ext[ACC_W-1]) &&
          (acc_nxt[c][ACC_W-1] != acc[c][ACC_W-1]))
        ovf_step = 1'b1;
    end
  end

  // Operand capture; the LOAD states imply in_ready so in_valid alone marks a transfer
  always_ff @(posedge clk) begin
    if (state == S_LOAD_A && bus.in_valid)
      a_mem[AW'(cnt)] <= bus.in_data;
    if (state == S_LOAD_B && bus.in_valid)
      b_mem[BW'(cnt)] <= bus.in_data;
  end

  // Job sequencing, accumulators and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      k_idx         <= '0;
      o_idx         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      for (int c = 0; c < NC; c++) acc[c] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LOAD_A;
            busy         <= 1'b1;
            bus.in_ready <= 1'b1;
            cnt          <= '0;
            if (!accumulate) begin
              overflow <= 1'b0;
              for (int c = 0; c < NC; c++) acc[c] <= '0;
            end
          end
        end

        S_LOAD_A: begin
          if (bus.in_valid) begin
            if (cnt == LW'(NA - 1)) begin
              cnt   <= '0;
              state <= S_LOAD_B;
            end else begin
              cnt <= cnt + LW'(1);
            end
          end
        end

        S_LOAD_B: begin
          if (bus.in_valid) begin
            if (cnt == LW'(NB - 1)) begin
              cnt          <= '0;
              k_idx        <= '0;
              bus.in_ready <= 1'b0;
              state        <= S_COMPUTE;
            end else begin
              cnt <= cnt + LW'(1);
            end
          end
        end

        S_COMPUTE: begin
          for (int c = 0; c < NC; c++) acc[c] <= acc_nxt[c];
          if (ovf_step) overflow <= 1'b1;
          if (k_idx == KW'(K - 1)) begin
            // First result comes straight from the final MAC step
            state         <= S_OUT;
            k_idx         <= '0;
            o_idx         <= '0;
            bus.out_valid <= 1'b1;
            bus.out_data  <= acc_nxt[0];
            bus.out_last  <= (NC == 1);
          end else begin
            k_idx <= k_idx + KW'(1);
          end
        end

        S_OUT: begin
          if (bus.out_ready) begin
            if (o_idx == CW'(NC - 1)) begin
              state         <= S_IDLE;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else begin
              o_idx        <= o_idx + CW'(1);
              bus.out_data <= acc[o_idx + CW'(1)];
              bus.out_last <= ((o_idx + CW'(1)) == CW'(NC - 1));
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_stream_core.sv
// tb/tb_matmul_stream_core.sv - self-checking bench for matmul_stream_core
module tb_matmul_stream_core;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int M  = 2;
  localparam int N  = 2;
  localparam int K  = 5;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic accumulate;
  logic busy;
  logic done;
  logic overflow;

  matmul_stream_core_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

  matmul_stream_core #(.DATA_W(DW), .ACC_W(AW), .M(M), .N(N), .K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .accumulate (accumulate),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DW-1:0] mat_a [M][K];
  logic signed [DW-1:0] mat_b [K][N];
  longint model_c [M*N];
  bit     model_ovf;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: C (+)= A x B with every add done in wide arithmetic, then range-checked and wrapped
  task automatic model_job(input bit acc_mode);
    longint s;
    logic signed [AW-1:0] w;
    if (!acc_mode) begin
      for (int c = 0; c < M*N; c++) model_c[c] = 0;
      model_ovf = 1'b0;
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < K; k++) begin
          s = model_c[i*N+j] + longint'(mat_a[i][k]) * longint'(mat_b[k][j]);
          if (s > 64'sd2147483647 || s < -64'sd2147483648) model_ovf = 1'b1;
          w = s[AW-1:0];
          model_c[i*N+j] = w;
        end
  endtask

  function automatic bit pick(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return (cyc % 2) == 0;
      2: return ((cyc % 4) == 1) || ((cyc % 4) == 2);
      default: return 1'(($urandom & 32'h3) != 0);
    endcase
  endfunction

  task automatic set_basic();
    int av [M][K] = '{'{1, 2, 2, 2, 2}, '{3, 4, 4, 4, 4}};
    int bv [K][N] = '{'{5, 6}, '{7, 8}, '{5, 6}, '{7, 8}, '{5, 6}};
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) mat_a[i][k] = DW'(av[i][k]);
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mat_b[k][j] = DW'(bv[k][j]);
  endtask

  task automatic run_job(input bit acc_mode, input int in_mode, input int out_mode, input bit poke);
    logic signed [DW-1:0] words [M*K + K*N];
    longint expv [M*N];
    int idx;
    int cyc;
    int first_valid;
    bit xfer;
    bit rdy;
    bit held;
    logic signed [AW-1:0] held_d;
    logic held_l;

    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) words[i*K+k] = mat_a[i][k];
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) words[M*K + k*N + j] = mat_b[k][j];
    model_job(acc_mode);
    for (int c = 0; c < M*N; c++) expv[c] = model_c[c];

    @(negedge clk);
    start = 1'b1;
    accumulate = acc_mode;
    @(negedge clk);
    start = 1'b0;
    accumulate = $urandom_range(0, 1);
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", bus.in_ready, 1);

    idx = 0;
    cyc = 0;
    while (idx < M*K + K*N && cyc < BUDGET) begin
      bus.in_valid = pick(in_mode, cyc);
      bus.in_data  = bus.in_valid ? words[idx] : DW'($urandom);
      start = poke && (idx >= M*K) && (cyc % 3 == 0);
      xfer = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (xfer) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    if (idx < M*K + K*N) chk("load_timeout", idx, M*K + K*N);
    chk("in_ready_after_load", bus.in_ready, 0);

    idx = 0;
    cyc = 0;
    held = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    first_valid = -1;
    while (idx < M*N && cyc < BUDGET) begin
      rdy = pick(out_mode, cyc);
      bus.out_ready = rdy;
      start = poke && (cyc % 2 == 1);
      if (held) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, held_d);
        chk("stall_last", bus.out_last, held_l);
      end
      if (bus.out_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          chk("compute_latency", cyc, K);
        end
        if (rdy) begin
          chk($sformatf("c%0d_data", idx), bus.out_data, expv[idx]);
          chk($sformatf("c%0d_last", idx), bus.out_last, (idx == M*N-1));
          idx++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_d = bus.out_data;
          held_l = bus.out_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    if (idx < M*N) chk("out_timeout", idx, M*N);
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("out_valid_at_done", bus.out_valid, 0);
    chk("overflow", overflow, model_ovf);
    @(negedge clk);
    chk("done_single", done, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    accumulate = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    model_ovf = 1'b0;
    for (int c = 0; c < M*N; c++) model_c[c] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Basic job, then accumulate on top of it
    set_basic();
    run_job(1'b0, 0, 0, 1'b0);
    run_job(1'b1, 0, 0, 1'b0);

    // Gaps on input, 0,1,1,0 backpressure on output
    run_job(1'b0, 1, 2, 1'b0);

    // Signed extremes wrap and set overflow; the next fresh job clears it
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) mat_a[i][k] = -16'sd32768;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) mat_b[k][j] = -16'sd32768;
    run_job(1'b0, 0, 0, 1'b0);
    set_basic();
    run_job(1'b0, 0, 0, 1'b0);

    // start pulses during LOAD_B and OUT are ignored
    run_job(1'b0, 0, 1, 1'b1);

    // Reset after three B words aborts the job
    @(negedge clk);
    start = 1'b1;
    accumulate = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < M*K + 3; w++) begin
      bus.in_valid = 1'b1;
      bus.in_data = (w < M*K) ? mat_a[w / K][w % K] : mat_b[(w - M*K) / N][(w - M*K) % N];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midreset");
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_reset_quiet", {done, bus.out_valid, busy}, 0);
    end
    for (int c = 0; c < M*N; c++) model_c[c] = 0;
    model_ovf = 1'b0;
    // accumulate=1 here shows the reset itself zeroed the accumulators
    run_job(1'b1, 0, 0, 1'b0);

    // Randomised operands, modes and accumulate chains
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < M; i++) for (int k = 0; k < K; k++)
        mat_a[i][k] = (r % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 200)) - 16'sd100;
      for (int k = 0; k < K; k++) for (int j = 0; j < N; j++)
        mat_b[k][j] = (r % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 200)) - 16'sd100;
      run_job(1'($urandom_range(0, 1)), 3, 3, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_stream_core.md
# matmul_stream_core

Parametrised streaming successor to the fixed-operand `matmul_top` engine. It accepts the A (M×K) and B (K×N) operands as a single valid/ready word stream and computes C = A×B, or C += A×B in accumulate mode, on an M×N MAC array over K cycles. It returns the C elements on a valid/ready output stream with backpressure and raises a sticky overflow flag. It sits between the AXI-side operand buffers and the result writer.

## Interface
- DATA_W, 16, signed operand width
- ACC_W, 32, signed accumulator/result width; must be ≥ 2*DATA_W
- M, 2, rows of A and C
- N, 2, columns of B and C
- K, 5, inner dimension; must be ≥ 1
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; honoured only in IDLE
- accumulate  in  1  sampled with start; 1 = keep the existing accumulators
- in_valid  in  1  operand word valid
- in_ready  out  1  core accepts an operand word
- in_data  in  DATA_W  signed operand word
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts the result word
- out_data  out  ACC_W  signed result word
- out_last  out  1  marks C[M-1][N-1]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final result handshake
- overflow  out  1  sticky signed-overflow flag for the current accumulation chain

## Operation
- FSM states are IDLE, LOAD_A, LOAD_B, COMPUTE, OUT.
- IDLE: in_ready=0, out_valid=0. On start=1, latch accumulate and go to LOAD_A. If the latched accumulate=0, clear all M*N accumulators and overflow on this transition.
- start is ignored in every state except IDLE.
- LOAD_A: accept M*K words, row-major A[0][0], A[0][1] … A[M-1][K-1]. A word transfers only on in_valid && in_ready. After the last word, go to LOAD_B.
- LOAD_B: accept K*N words, row-major B[0][0] … B[K-1][N-1]. After the last word, go to COMPUTE.
- in_ready=1 throughout LOAD_A and LOAD_B, and 0 in all other states.
- COMPUTE: runs exactly K cycles with index k = 0..K-1. Each cycle, every accumulator updates as acc[i][j] += A[i][k]*B[k][j]. Then go to OUT.
- OUT: emit M*N words row-major C[0][0] … C[M-1][N-1]. out_last=1 only with the final word.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - After the final handshake, go to IDLE and pulse done for one cycle.
- Arithmetic:
  - The product is the full 2*DATA_W signed result, sign-extended to ACC_W.
  - Accumulation is two's-complement and wraps at ACC_W; there is no saturation.
  - overflow sets when any add overflows (both operands share a sign and the sum's sign differs). It stays set until a start with accumulate=0 or a reset.
- accumulate=1 on start: the accumulators keep their values from the previous job, so the results are C_prev + A×B. Operands are always reloaded.

## Timing
- Reset: state=IDLE; in_ready, out_valid, out_last, busy, done and overflow are all 0; out_data=0; every accumulator = 0.
- Reset in any state aborts the job the next cycle with no done pulse and no further outputs.
- start sampled at cycle t → busy=1 and in_ready=1 from cycle t+1.
- Last B word accepted at cycle u → COMPUTE occupies cycles u+1 … u+K → out_valid=1 from cycle u+K+1.
- Minimum job length with no stalls: 1 + M*K + K*N + K + M*N cycles to the final handshake; done follows on the next cycle.
- Gaps in in_valid or out_ready only stretch the LOAD and OUT phases. No data is dropped or duplicated.
- done and busy: busy drops in the same cycle done is high, i.e. the FSM is already in IDLE. A start in that cycle is accepted.

## Test plan
- Basic job, accumulate=0: A={{1,2,2,2,2},{3,4,4,4,4}}, B={{5,6},{7,8},{5,6},{7,8},{5,6}}, in_valid and out_ready held high → outputs 53, 62, 111, 130; out_last only with 130; one done pulse; overflow=0.
- Accumulate: repeat the basic job with accumulate=1 → outputs 106, 124, 222, 260.
- Backpressure and gaps: same operands, in_valid toggles 1/0 and out_ready pattern 0,1,1,0,… → the same four values in order, each held stable while stalled, no duplicates or drops.
- Signed extremes: every A and B word = -32768 → each product is 2^30, and the sum 5*2^30 wraps → all four outputs are 1073741824 and overflow=1. A following accumulate=0 job clears overflow.
- Start while busy: pulse start during LOAD_B and OUT → no effect; the result matches the basic job.
- Reset mid-job: assert rst for 1 cycle after 3 B words → all outputs return to reset values with no done pulse; then a fresh basic job → 53, 62, 111, 130.
